// File: rtl/alu4_seq.sv
// Sequencer that drives one external 4-bit ALU slice nibble-by-nibble to build a
// NIBBLES*4-bit operation, chaining carry and accumulating the zero flag.
module alu4_seq #(
  parameter int NIBBLES = 4,
  parameter int SLICE   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic                       b_inv,
  input  logic                       b_zero,
  input  logic                       cin,
  input  logic [NIBBLES*SLICE-1:0]   a,
  input  logic [NIBBLES*SLICE-1:0]   b,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLES*SLICE-1:0]   result,
  output logic                       carry_out,
  output logic                       zero,
  output logic                       overflow,
  output logic [SLICE-1:0]           alu_a,
  output logic [SLICE-1:0]           alu_b,
  output logic                       alu_b_inv,
  output logic                       alu_b_zero,
  output logic                       alu_y,
  output logic [1:0]                 alu_op,
  input  logic [SLICE-1:0]           alu_s,
  input  logic                       alu_c,
  input  logic                       alu_zero,
  input  logic                       alu_overflow
);

  localparam int W     = NIBBLES * SLICE;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W+1:0] base;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [1:0]       op_reg;
  logic             b_inv_reg;
  logic             b_zero_reg;
  logic             carry_reg;
  logic             zero_acc;
  logic             last;

  // SLICE is fixed at 4, so the nibble bit offset is idx with two zero LSBs.
  assign base = {idx, 2'b00};
  assign last = (idx == IDX_W'(NIBBLES - 1));

  assign alu_a      = a_reg[base +: SLICE];
  assign alu_b      = b_reg[base +: SLICE];
  assign alu_y      = carry_reg;
  assign alu_op     = op_reg;
  assign alu_b_inv  = b_inv_reg;
  assign alu_b_zero = b_zero_reg;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      b_inv_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      carry_reg  <= 1'b0;
      zero_acc   <= 1'b0;
      result     <= '0;
      carry_out  <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            op_reg     <= op;
            b_inv_reg  <= b_inv;
            b_zero_reg <= b_zero;
            carry_reg  <= cin;
            idx        <= '0;
            zero_acc   <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          result[base +: SLICE] <= alu_s;
          carry_reg             <= alu_c;
          zero_acc              <= zero_acc & alu_zero;
          if (last) begin
            carry_out <= alu_c;
            overflow  <= alu_overflow;
            zero      <= zero_acc & alu_zero;
            idx       <= '0;
            state     <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_seq.sv
// Bench for alu4_seq: a 4-nibble and a 1-nibble instance, each looped through a
// behavioural 4-bit slice, checked against a word-level reference model.
module tb_alu4_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic        b_inv, b_zero, cin;
  logic [15:0] a, b;

  logic        busy4, done4, co4, z4, ov4;
  logic [15:0] res4;
  logic [3:0]  aa4, ab4, as4;
  logic        abi4, abz4, ay4, ac4, az4, aov4;
  logic [1:0]  aop4;

  logic        busy1, done1, co1, z1, ov1;
  logic [3:0]  res1;
  logic [3:0]  aa1, ab1, as1;
  logic        abi1, abz1, ay1, ac1, az1, aov1;
  logic [1:0]  aop1;

  int compared   = 0;
  int mismatched = 0;
  logic y_hist [0:31];

  always #5 clk = ~clk;

  alu4_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .b_inv(b_inv), .b_zero(b_zero),
    .cin(cin), .a(a), .b(b), .busy(busy4), .done(done4), .result(res4),
    .carry_out(co4), .zero(z4), .overflow(ov4), .alu_a(aa4), .alu_b(ab4),
    .alu_b_inv(abi4), .alu_b_zero(abz4), .alu_y(ay4), .alu_op(aop4),
    .alu_s(as4), .alu_c(ac4), .alu_zero(az4), .alu_overflow(aov4)
  );

  alu4_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .b_inv(b_inv), .b_zero(b_zero),
    .cin(cin), .a(a[3:0]), .b(b[3:0]), .busy(busy1), .done(done1), .result(res1),
    .carry_out(co1), .zero(z1), .overflow(ov1), .alu_a(aa1), .alu_b(ab1),
    .alu_b_inv(abi1), .alu_b_zero(abz1), .alu_y(ay1), .alu_op(aop1),
    .alu_s(as1), .alu_c(ac1), .alu_zero(az1), .alu_overflow(aov1)
  );

  // External slice: 00 add, 01 and, 10 or, 11 xor; b_zero wins over b_inv.
  function automatic logic [6:0] slice(input logic [3:0] x, input logic [3:0] y,
                                       input logic [1:0] o, input logic bi, bz, ci);
    logic [3:0] bb, r;
    logic [4:0] s;
    logic c, v;
    bb = bz ? 4'h0 : (bi ? ~y : y);
    c = 1'b0;
    v = 1'b0;
    case (o)
      2'b00: begin
        s = {1'b0, x} + {1'b0, bb} + {4'b0, ci};
        r = s[3:0];
        c = s[4];
        v = (x[3] == bb[3]) && (r[3] != x[3]);
      end
      2'b01:   r = x & bb;
      2'b10:   r = x | bb;
      default: r = x ^ bb;
    endcase
    return {v, (r == 4'h0), c, r};
  endfunction

  always_comb {aov4, az4, ac4, as4} = slice(aa4, ab4, aop4, abi4, abz4, ay4);
  always_comb {aov1, az1, ac1, as1} = slice(aa1, ab1, aop1, abi1, abz1, ay1);

  // Whole-word reference: n nibbles of operands treated as one integer.
  function automatic void model(input int n, input logic [15:0] ta, tb,
                                input logic [1:0] top, input logic tbi, tbz, tci,
                                output logic [15:0] r, output logic co, ov, z);
    int w;
    logic [16:0] mask, aa, bb, s;
    w    = 4 * n;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, ta} & mask;
    bb   = tbz ? 17'd0 : ((tbi ? ~{1'b0, tb} : {1'b0, tb}) & mask);
    co   = 1'b0;
    case (top)
      2'b00: begin
        s  = aa + bb + 17'(tci);
        co = s[w];
      end
      2'b01:   s = aa & bb;
      2'b10:   s = aa | bb;
      default: s = aa ^ bb;
    endcase
    r  = 16'(s & mask);
    ov = (top == 2'b00) && (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    z  = (r == 16'h0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge after done.
  task automatic run_op(input int sel, input logic [15:0] ta, tb, input logic [1:0] top,
                        input logic tbi, tbz, tci, input bit spam);
    int n, c;
    logic [15:0] er;
    logic eco, eov, ez, dn;
    n = (sel == 1) ? 1 : 4;
    model(n, ta, tb, top, tbi, tbz, tci, er, eco, eov, ez);
    a = ta; b = tb; op = top; b_inv = tbi; b_zero = tbz; cin = tci; start = 1'b1;
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      y_hist[c] = ay4;
      dn = (sel == 1) ? done1 : done4;
      check("busy_run", 64'((sel == 1) ? busy1 : busy4), 64'd1);
      if (spam && c <= 3) start = 1'b1; else start = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      if (dn) break;
    end
    start = 1'b0;
    check("done_latency", 64'(c), 64'(n + 1));
    if (sel == 1) begin
      check("result1", 64'(res1), 64'(er));
      check("carry1", 64'(co1), 64'(eco));
      check("zero1", 64'(z1), 64'(ez));
      check("ovf1", 64'(ov1), 64'(eov));
    end else begin
      check("result4", 64'(res4), 64'(er));
      check("carry4", 64'(co4), 64'(eco));
      check("zero4", 64'(z4), 64'(ez));
      check("ovf4", 64'(ov4), 64'(eov));
    end
    @(negedge clk);
    check("done_pulse", 64'((sel == 1) ? done1 : done4), 64'd0);
    check("busy_idle", 64'((sel == 1) ? busy1 : busy4), 64'd0);
    if (spam) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("spam_no_done", 64'(done4), 64'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; b_inv = 1'b0; b_zero = 1'b0; cin = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_done", 64'(done4), 64'd0);
    check("rst_result", 64'(res4), 64'd0);
    check("rst_flags", 64'({co4, z4, ov4}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 16'h00FF, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("add_literal", 64'({res4, co4, z4, ov4}), 64'({16'h0100, 3'b000}));
    check("alu_y_nib0", 64'(y_hist[1]), 64'd0);
    check("alu_y_nib1", 64'(y_hist[2]), 64'd1);
    check("alu_y_nib2", 64'(y_hist[3]), 64'd1);
    check("alu_y_nib3", 64'(y_hist[4]), 64'd0);
    run_op(0, 16'h1234, 16'h1234, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sub_literal", 64'({res4, co4, z4, ov4}), 64'({16'h0000, 3'b110}));
    run_op(0, 16'hFFFF, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(0, 16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_literal", 64'({res4, co4, z4, ov4}), 64'({16'h8000, 3'b001}));
    run_op(0, 16'h1111, 16'h2222, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++)
      run_op(0, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b0);

    // Reset in cycle T+2 abandons the operation.
    a = 16'h4321; b = 16'h1111; op = 2'b00; b_inv = 1'b0; b_zero = 1'b0; cin = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_busy", 64'(busy4), 64'd0);
    check("mid_rst_done", 64'(done4), 64'd0);
    check("mid_rst_result", 64'(res4), 64'd0);
    check("mid_rst_flags", 64'({co4, z4, ov4}), 64'd0);
    check("mid_rst_latch", 64'({aa4, ab4, ay4}), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_rst_no_done", 64'({done4, busy4}), 64'd0);
    end
    run_op(0, 16'hA5A5, 16'h0F0F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back with start held high on both instances.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    a = 16'h9AB7; b = 16'h6559; op = 2'b00; b_inv = 1'b0; b_zero = 1'b0; cin = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      logic [15:0] er;
      logic eco, eov, ez;
      @(negedge clk);
      check("b2b_done4", 64'(done4), 64'(c % 6 == 5));
      check("b2b_busy4", 64'(busy4), 64'(c % 6 != 0));
      check("b2b_done1", 64'(done1), 64'(c % 3 == 2));
      check("b2b_busy1", 64'(busy1), 64'(c % 3 != 0));
      if (c % 6 == 5) begin
        model(4, a, b, op, b_inv, b_zero, cin, er, eco, eov, ez);
        check("b2b_res4", 64'({res4, co4, z4, ov4}), 64'({er, eco, ez, eov}));
      end
      if (c % 3 == 2) begin
        model(1, a, b, op, b_inv, b_zero, cin, er, eco, eov, ez);
        check("b2b_res1", 64'({res1, co1, z1, ov1}), 64'({er[3:0], eco, ez, eov}));
      end
    end
    start = 1'b0;

    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op(1, 16'h0007, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("n1_ovf_literal", 64'({res1, co1, z1, ov1}), 64'({4'h8, 3'b001}));
    for (int i = 0; i < 8; i++)
      run_op(1, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu4_seq.md
Name: alu4_seq

Overview:
- Multi-cycle sequencer that drives one external 4-bit ALU slice (alu4) nibble-by-nibble to perform NIBBLES*4-bit operations.
- Chains carry between nibbles, accumulates zero across all nibbles, and captures carry-out and overflow from the final (MSB) nibble.
- Sits between the register/operand front-end (start/done handshake) and the single shared alu4 instance; one operation in flight at a time.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (operand width = NIBBLES*4); legal range 1..16.
- SLICE, 4, width of the external ALU slice; fixed at 4, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- op  input  2  ALU operation code, passed to slice unchanged
- b_inv  input  1  invert B (subtract when combined with cin=1)
- b_zero  input  1  force B to zero
- cin  input  1  carry-in to nibble 0
- a  input  NIBBLES*4  operand A
- b  input  NIBBLES*4  operand B
- busy  output  1  high from the cycle after accepted start until done cycle inclusive
- done  output  1  one-cycle pulse, result valid
- result  output  NIBBLES*4  assembled sum/logic result
- carry_out  output  1  carry from MSB nibble
- zero  output  1  all result bits clear
- overflow  output  1  slice overflow flag from MSB nibble
- alu_a  output  4  current nibble of latched A
- alu_b  output  4  current nibble of latched B
- alu_b_inv  output  1  latched b_inv
- alu_b_zero  output  1  latched b_zero
- alu_y  output  1  carry into current nibble
- alu_op  output  2  latched op
- alu_s  input  4  slice sum
- alu_c  input  1  slice carry-out
- alu_zero  input  1  slice zero flag
- alu_overflow  input  1  slice overflow flag

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE. idx counter width clog2(NIBBLES), min 1.
- Reset, synchronous and active-high, clears all outputs to 0: busy, done, result, carry_out, zero, overflow. It also clears latched operands, idx, and the carry register. Reset during RUN/DONE abandons the operation; no done pulse.
- IDLE: when start=1, latch a, b, op, b_inv, b_zero, and cin into operand regs, set carry_reg=cin, idx=0, zero_acc=1, and go to RUN. start=0 holds state. done=0.
- RUN, one nibble per cycle:
  - alu_a/alu_b are combinational selects of latched A/B[idx*4+:4].
  - alu_y=carry_reg. alu_op/alu_b_inv/alu_b_zero come from latches.
  - On the clock edge: result[idx*4+:4]<=alu_s, carry_reg<=alu_c, zero_acc<=zero_acc&alu_zero.
  - idx!=NIBBLES-1: idx<=idx+1.
  - idx==NIBBLES-1: carry_out<=alu_c, overflow<=alu_overflow, zero<=zero_acc&alu_zero, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy deasserts the same edge done deasserts.
- Latency: start sampled at edge T; done high in cycle T+NIBBLES+1. Back-to-back: start may be accepted the cycle done falls (IDLE).
- start while busy is ignored, not queued. Operand inputs may change freely after acceptance.
- result/carry_out/zero/overflow hold their value until the next accepted operation completes. result is updated in place during RUN; consumers use it only on done.
- Outside RUN, alu_* outputs still reflect latched values at idx (idx=0 in IDLE); the slice output is ignored.
- NIBBLES=1: RUN lasts one cycle; done at T+2.
- No combinational path from start to any output.

Test Plan:
- Add with bench ALU model (op=2'b00 add), NIBBLES=4: a=16'h00FF, b=16'h0001, cin=0 -> done at T+5, result=16'h0100, carry_out=0, zero=0, overflow=0. Monitor shows alu_y=1 on nibbles 1 and 2.
- Subtract with a=16'h1234, b=16'h1234, b_inv=1, cin=1 -> result=16'h0000, zero=1, carry_out=1, overflow=0.
- Signed overflow with a=16'h7FFF, b=16'h0001, add -> result=16'h8000, overflow=1, carry_out=0; a=16'hFFFF, b=16'h0001 -> result=0, carry_out=1, zero=1.
- Pulse start again at cycles 1..3 after acceptance with different operands -> ignored; result matches the first operation only; exactly one done pulse.
- Assert rst in cycle T+2 mid-RUN -> next cycle all outputs 0, state IDLE, no done. A new start afterwards completes correctly.
- Back-to-back: start held high continuously -> done every NIBBLES+2 cycles, busy low exactly one cycle between operations. Repeat with NIBBLES=1 -> done at T+2.
